mem_wb_pipe: RTL and testbench

Parametrised MEM/WB stage for the five-stage core. It registers EX/MEM results and decides whether each one writes back. For loads it waits on a variable-latency data-memory response and extracts sub-word data (LB/LH/LW/LBU/LHU) with sign/zero extension. It stalls upstream while a load is outstanding and supports flush and a response timeout.

---
 rtl/mem_wb_pipe.sv | 122 ++++++++++++
 tb/tb_mem_wb_pipe.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM/WB stage with variable-latency load handling; `define MEMWB_MDU_EN adds the MDU result path.
module mem_wb_pipe #(
    parameter int XLEN        = 32,
    parameter int ACK_TIMEOUT = 15,
    parameter int TMR_W       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid_i,
    input  logic [31:0]     ex_ir_i,
    input  logic [XLEN-1:0] ex_alu_i,
`ifdef MEMWB_MDU_EN
    input  logic            mdu_op_i,
    input  logic [XLEN-1:0] mdu_res_i,
`endif
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_ack_i,
    input  logic            stall_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            wb_en_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            misalign_o,
    output logic            timeout_o
);
    localparam logic [0:0] S_IDLE = 1'b0, S_WAIT = 1'b1;
    logic [0:0]       r_state;
    logic [TMR_W-1:0] r_cnt;
    logic [4:0]       r_ld_rd, r_wb_rd;
    logic [2:0]       r_f3;
    logic [1:0]       r_addr;
    logic             r_wb_en, r_mis, r_to;
    logic [XLEN-1:0]  r_wb_data;
    logic [6:0]       w_op;
    logic [4:0]       w_rd, w_ld_rd;
    logic [2:0]       w_f3;
    logic [1:0]       w_addr;
    logic             w_wait, w_load, w_wr_op, w_f3_ok, w_mis, w_done, w_unused;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [XLEN-1:0]  w_ext, w_res;
    assign w_wait  = r_state == S_WAIT;
    assign w_op    = ex_ir_i[6:0];
    assign w_rd    = ex_ir_i[11:7];
    assign w_load  = ex_valid_i && w_op == 7'b0000011;
    assign w_wr_op = w_op inside {7'b0110011, 7'b0010011, 7'b0010111, 7'b1110011,
                                  7'b0110111, 7'b0000011, 7'b1101111, 7'b1100111};
    // While waiting, extraction uses the fields latched at issue; EX/MEM may change meanwhile.
    assign w_f3    = w_wait ? r_f3 : ex_ir_i[14:12];
    assign w_addr  = w_wait ? r_addr : ex_alu_i[1:0];
    assign w_ld_rd = w_wait ? r_ld_rd : w_rd;
    assign w_f3_ok = w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign w_mis   = (w_f3[1:0] == 2'b01 && w_addr[0]) || (w_f3 == 3'b010 && w_addr != 2'b00);
    assign w_byte  = mem_rdata_i[{w_addr, 3'b000} +: 8];
    assign w_half  = w_addr[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    assign w_ext   = w_f3[1] ? mem_rdata_i
                   : w_f3[0] ? {{(XLEN-16){~w_f3[2] & w_half[15]}}, w_half}
                   : {{(XLEN-8){~w_f3[2] & w_byte[7]}}, w_byte};
    assign w_done  = mem_ack_i && !flush_i && (w_wait || (w_load && !stall_i));
`ifdef MEMWB_MDU_EN
    assign w_res   = mdu_op_i ? mdu_res_i : ex_alu_i;
`else
    assign w_res   = ex_alu_i;
`endif
    assign w_unused = ^ex_ir_i[31:15];
    assign stall_o = rst_n && !mem_ack_i && (w_wait || (w_load && !stall_i && !flush_i));
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ld_rd   <= '0;
            r_f3      <= '0;
            r_addr    <= '0;
            r_wb_en   <= 1'b0;
            r_mis     <= 1'b0;
            r_to      <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else begin
            r_wb_en <= 1'b0;
            r_mis   <= 1'b0;
            r_to    <= 1'b0;
            if (flush_i) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
            end else if (w_done) begin
                r_wb_en   <= w_f3_ok && !w_mis && w_ld_rd != 5'd0;
                r_mis     <= w_mis;
                r_wb_rd   <= w_ld_rd;
                r_wb_data <= w_ext;
                r_state   <= S_IDLE;
                r_cnt     <= '0;
            end else if (w_wait) begin
                if (r_cnt == TMR_W'(ACK_TIMEOUT)) begin
                    r_to    <= 1'b1;
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (ex_valid_i && !stall_i) begin
                if (w_load) begin
                    r_ld_rd <= w_rd;
                    r_f3    <= ex_ir_i[14:12];
                    r_addr  <= ex_alu_i[1:0];
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end else begin
                    r_wb_en   <= w_wr_op && w_rd != 5'd0;
                    r_wb_rd   <= w_rd;
                    r_wb_data <= w_res;
                end
            end
        end
    end
    assign wb_en_o    = r_wb_en;
    assign wb_rd_o    = r_wb_rd;
    assign wb_data_o  = r_wb_data;
    assign misalign_o = r_mis;
    assign timeout_o  = r_to;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: randomized self-checking bench for mem_wb_pipe against a behavioural writeback/load model.
module tb_mem_wb_pipe;
    localparam int TO = 15;
    typedef struct {
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        int          delay;
    } ld_t;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ex_valid_i = 1'b0, mem_ack_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
    logic [31:0] ex_ir_i = '0, ex_alu_i = '0, mem_rdata_i = '0;
`ifdef MEMWB_MDU_EN
    logic        mdu_op_i = 1'b0;
    logic [31:0] mdu_res_i = '0;
`endif
    logic        stall_o, wb_en_o, misalign_o, timeout_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    int          n_cmp = 0, n_err = 0;
    int          obs_stalls;
    bit          obs_early;
    logic        obs_en, obs_mis, obs_to;
    logic [4:0]  obs_rd;
    logic [31:0] obs_data;

    always #5 clk = ~clk;

    mem_wb_pipe #(.XLEN(32), .ACK_TIMEOUT(TO), .TMR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid_i), .ex_ir_i(ex_ir_i), .ex_alu_i(ex_alu_i),
`ifdef MEMWB_MDU_EN
        .mdu_op_i(mdu_op_i), .mdu_res_i(mdu_res_i),
`endif
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i), .stall_i(stall_i), .flush_i(flush_i),
        .stall_o(stall_o), .wb_en_o(wb_en_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .misalign_o(misalign_o), .timeout_o(timeout_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid_i = 1'b0;
        mem_ack_i  = 1'b0;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
    endtask

    function automatic bit is_wb(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h17, 7'h73, 7'h37, 7'h03, 7'h6F, 7'h67};
    endfunction

    function automatic logic [6:0] rand_nonload_op();
        logic [6:0] pool [10];
        logic [6:0] op;
        pool = '{7'h33, 7'h13, 7'h17, 7'h73, 7'h37, 7'h6F, 7'h67, 7'h23, 7'h63, 7'h0F};
        op = ($urandom_range(0, 3) == 0) ? 7'($urandom()) : pool[$urandom_range(0, 9)];
        return (op == 7'h03) ? 7'h33 : op;
    endfunction

    // Reference load result computed arithmetically from the byte/half lane rules.
    function automatic void ref_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] a,
                                     input logic [31:0] d, output bit en, output bit mis, output logic [31:0] v);
        int unsigned b, h;
        bit ok;
        b   = (d >> (8 * int'(a))) % 256;
        h   = (d >> (16 * (int'(a) / 2))) % 65536;
        ok  = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        mis = ((f3 == 1 || f3 == 5) && (a % 2 == 1)) || (f3 == 2 && a != 0);
        case (f3)
            3'd0: v = (b < 128) ? b : b + 32'hFFFF_FF00;
            3'd4: v = b;
            3'd1: v = (h < 32768) ? h : h + 32'hFFFF_0000;
            3'd5: v = h;
            3'd2: v = d;
            default: v = '0;
        endcase
        en = ok && !mis && rd != 0;
    endfunction

    // delay: 0 = ack with the request, d>0 = ack d cycles later, <0 or too late = never.
    task automatic run_load(input logic [4:0] rd, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input int delay);
        obs_stalls  = 0;
        obs_early   = 0;
        ex_valid_i  = 1'b1;
        ex_ir_i     = $urandom();
        ex_ir_i[14:0] = {f3, rd, 7'h03};
        ex_alu_i    = addr;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        mem_ack_i   = (delay == 0);
        mem_rdata_i = (delay == 0) ? rdata : $urandom();
        #1 obs_stalls += int'(stall_o);
        tick();
        if (delay != 0) begin
            for (int k = 0; k <= TO; k++) begin
                ex_ir_i     = $urandom();
                ex_alu_i    = $urandom();
                ex_valid_i  = 1'($urandom_range(0, 1));
                stall_i     = 1'($urandom_range(0, 1));
                mem_ack_i   = (k == delay - 1);
                mem_rdata_i = mem_ack_i ? rdata : $urandom();
                #1 obs_stalls += int'(stall_o);
                tick();
                if (mem_ack_i || k == TO) break;
                if (wb_en_o || misalign_o || timeout_o) obs_early = 1;
            end
        end
        obs_en = wb_en_o; obs_mis = misalign_o; obs_to = timeout_o;
        obs_rd = wb_rd_o; obs_data = wb_data_o;
        idle_inputs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ex_valid_i = 1'b1;
            ex_ir_i = $urandom();
            ex_ir_i[6:0] = 7'h03;
            ex_alu_i = $urandom();
            #1;
            n_cmp++;
            if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_o); end
            tick();
        end
        n_cmp++;
        if ({wb_en_o, misalign_o, timeout_o, stall_o} !== 4'b0 || wb_rd_o !== 5'd0 || wb_data_o !== 32'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got en=%b mis=%b to=%b st=%b rd=%0d data=%h want all 0",
                     wb_en_o, misalign_o, timeout_o, stall_o, wb_rd_o, wb_data_o);
        end
        rst_n = 1'b1;
        ex_valid_i = 1'b1;
        ex_ir_i = 32'h0000_2583;
        ex_alu_i = 32'h100;
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (stall_o !== 1'b1) begin n_err++; $display("FAIL wait_stall_before_reset: got %b want 1", stall_o); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (stall_o !== 1'b0) begin n_err++; $display("FAIL stall_after_reset: got %b want 0", stall_o); end
        obs_early = 0;
        for (int i = 0; i < TO + 3; i++) begin
            tick();
            if (timeout_o || wb_en_o || stall_o) obs_early = 1;
        end
        n_cmp++;
        if (obs_early) begin n_err++; $display("FAIL reset_kills_load: got activity after reset want none"); end
    endtask

    task automatic test_alu();
        logic [31:0] irs [2];
        logic        exp_en [2];
        irs = '{32'h0020_8293, 32'h0020_8013};
        exp_en = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            ex_valid_i = 1'b1;
            ex_ir_i = irs[i];
            ex_alu_i = 32'h1234;
            #1;
            n_cmp++;
            if (stall_o !== 1'b0) begin n_err++; $display("FAIL alu%0d_stall: got %b want 0", i, stall_o); end
            tick();
            n_cmp++;
            if (wb_en_o !== exp_en[i]) begin n_err++; $display("FAIL alu%0d_en: got %b want %b", i, wb_en_o, exp_en[i]); end
            if (exp_en[i]) begin
                n_cmp++;
                if (wb_rd_o !== 5'd5 || wb_data_o !== 32'h1234) begin
                    n_err++;
                    $display("FAIL alu%0d_data: got rd=%0d data=%h want rd=5 data=00001234", i, wb_rd_o, wb_data_o);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_load();
        ld_t dir [9];
        ld_t c;
        bit e_en, e_mis, e_to;
        logic [31:0] e_val;
        int e_st;
        dir = '{'{5'd6, 3'd0, 32'h1003, 32'h80FF_0000, 0},
                '{5'd6, 3'd4, 32'h1003, 32'h80FF_0000, 0},
                '{5'd7, 3'd1, 32'h2002, 32'h8001_7FFF, 3},
                '{5'd8, 3'd2, 32'h1002, 32'h1122_3344, 0},
                '{5'd9, 3'd2, 32'h1000, 32'h1234_5678, -1},
                '{5'd9, 3'd2, 32'h1000, 32'hCAFE_F00D, TO + 1},
                '{5'd0, 3'd2, 32'h1000, 32'h5555_AAAA, 2},
                '{5'd12, 3'd3, 32'h1000, 32'h0000_0001, 1},
                '{5'd13, 3'd5, 32'h1001, 32'hFFFF_0000, 2}};
        for (int i = 0; i < 39; i++) begin
            if (i < 9) c = dir[i];
            else begin
                c.rd = 5'($urandom());
                c.f3 = 3'($urandom());
                c.addr = $urandom();
                c.data = $urandom();
                c.delay = $urandom_range(0, TO + 3);
            end
            run_load(c.rd, c.f3, c.addr, c.data, c.delay);
            ref_load(c.rd, c.f3, c.addr[1:0], c.data, e_en, e_mis, e_val);
            e_to = c.delay < 0 || c.delay > TO + 1;
            e_st = e_to ? TO + 2 : c.delay;
            if (e_to) begin e_en = 0; e_mis = 0; end
            n_cmp += 4;
            if (obs_stalls != e_st) begin n_err++; $display("FAIL load%0d_stall_cycles: got %0d want %0d", i, obs_stalls, e_st); end
            if (obs_early) begin n_err++; $display("FAIL load%0d_early: got output pulse while waiting want none", i); end
            if (obs_to !== e_to) begin n_err++; $display("FAIL load%0d_timeout: got %b want %b", i, obs_to, e_to); end
            if (obs_en !== e_en || obs_mis !== e_mis) begin
                n_err++;
                $display("FAIL load%0d_en_mis: got en=%b mis=%b want en=%b mis=%b", i, obs_en, obs_mis, e_en, e_mis);
            end
            if (e_en) begin
                n_cmp++;
                if (obs_rd !== c.rd || obs_data !== e_val) begin
                    n_err++;
                    $display("FAIL load%0d_data: got rd=%0d data=%h want rd=%0d data=%h", i, obs_rd, obs_data, c.rd, e_val);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        ex_valid_i = 1'b1;
        ex_ir_i = 32'h0020_8293;
        ex_alu_i = 32'h55;
        stall_i = 1'b1;
        tick();
        n_cmp++;
        if (wb_en_o !== 1'b0) begin n_err++; $display("FAIL stall_bubble: got en=%b want 0", wb_en_o); end
        ex_ir_i = 32'h0000_2303;
        #1;
        n_cmp++;
        if (stall_o !== 1'b0) begin n_err++; $display("FAIL stall_load_no_hold: got %b want 0", stall_o); end
        tick();
        stall_i = 1'b0;
        ex_ir_i = 32'h0020_8293;
        #1;
        n_cmp++;
        if (wb_en_o !== 1'b0 || stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL stall_load_skipped: got en=%b st=%b want 0 0", wb_en_o, stall_o);
        end
        tick();
        n_cmp++;
        if (wb_en_o !== 1'b1 || wb_data_o !== 32'h55) begin
            n_err++;
            $display("FAIL stall_resume: got en=%b data=%h want 1 00000055", wb_en_o, wb_data_o);
        end
        ex_valid_i = 1'b0;
        tick();
        n_cmp++;
        if (wb_en_o !== 1'b0) begin n_err++; $display("FAIL invalid_bubble: got en=%b want 0", wb_en_o); end
        idle_inputs();
    endtask

    task automatic test_flush();
        ex_valid_i = 1'b1;
        ex_ir_i = 32'h0000_2583;
        ex_alu_i = 32'h3000;
        tick();
        ex_valid_i = 1'b0;
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        n_cmp++;
        if (wb_en_o !== 1'b0 || timeout_o !== 1'b0 || stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_wait: got en=%b to=%b st=%b want 0 0 0", wb_en_o, timeout_o, stall_o);
        end
        mem_ack_i = 1'b1;
        mem_rdata_i = $urandom();
        tick();
        mem_ack_i = 1'b0;
        n_cmp++;
        if (wb_en_o !== 1'b0 || misalign_o !== 1'b0) begin
            n_err++;
            $display("FAIL stray_ack: got en=%b mis=%b want 0 0", wb_en_o, misalign_o);
        end
        obs_early = 0;
        for (int i = 0; i < TO + 3; i++) begin
            tick();
            if (timeout_o || stall_o) obs_early = 1;
        end
        n_cmp++;
        if (obs_early) begin n_err++; $display("FAIL flush_clears_timer: got timeout/stall after flush want none"); end
        ex_valid_i = 1'b1;
        ex_ir_i = 32'h0000_2583;
        tick();
        ex_valid_i = 1'b0;
        mem_ack_i = 1'b1;
        flush_i = 1'b1;
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (wb_en_o !== 1'b0 || stall_o !== 1'b0) begin
            n_err++;
            $display("FAIL flush_beats_ack: got en=%b st=%b want 0 0", wb_en_o, stall_o);
        end
        ex_valid_i = 1'b1;
        ex_ir_i = 32'h0020_8293;
        flush_i = 1'b1;
        tick();
        idle_inputs();
        n_cmp++;
        if (wb_en_o !== 1'b0) begin n_err++; $display("FAIL flush_idle: got en=%b want 0", wb_en_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ir, alu, rd_data;
        bit e_en, e_mis;
        logic [31:0] e_val;
        int kind;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            ir = $urandom();
            alu = $urandom();
            rd_data = $urandom();
            ex_valid_i = (kind != 0);
            if (kind == 1) begin
                ir[6:0] = 7'h03;
                mem_ack_i = 1'b1;
                ref_load(ir[11:7], ir[14:12], alu[1:0], rd_data, e_en, e_mis, e_val);
            end else begin
                if (kind != 0) ir[6:0] = rand_nonload_op();
                mem_ack_i = 1'($urandom_range(0, 1));
                e_en = (kind != 0) && is_wb(ir[6:0]) && ir[11:7] != 0;
                e_mis = 0;
                e_val = alu;
            end
            ex_ir_i = ir;
            ex_alu_i = alu;
            mem_rdata_i = rd_data;
            #1;
            n_cmp++;
            if (stall_o !== 1'b0) begin n_err++; $display("FAIL b2b%0d_stall: got %b want 0", i, stall_o); end
            tick();
            n_cmp++;
            if (wb_en_o !== e_en || misalign_o !== e_mis) begin
                n_err++;
                $display("FAIL b2b%0d_en_mis: got en=%b mis=%b want en=%b mis=%b", i, wb_en_o, misalign_o, e_en, e_mis);
            end
            if (e_en) begin
                n_cmp++;
                if (wb_rd_o !== ir[11:7] || wb_data_o !== e_val) begin
                    n_err++;
                    $display("FAIL b2b%0d_data: got rd=%0d data=%h want rd=%0d data=%h", i, wb_rd_o, wb_data_o, ir[11:7], e_val);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

`ifdef MEMWB_MDU_EN
    task automatic test_mdu();
        ex_valid_i = 1'b1;
        ex_ir_i = 32'h0020_8293;
        ex_alu_i = 32'h1234;
        mdu_op_i = 1'b1;
        mdu_res_i = 32'hDEAD;
        tick();
        n_cmp++;
        if (wb_en_o !== 1'b1 || wb_data_o !== 32'hDEAD) begin
            n_err++;
            $display("FAIL mdu_sel: got en=%b data=%h want 1 0000dead", wb_en_o, wb_data_o);
        end
        ex_ir_i = 32'h0000_2303;
        ex_alu_i = 32'h2000;
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'hABCD_0123;
        tick();
        n_cmp++;
        if (wb_en_o !== 1'b1 || wb_data_o !== 32'hABCD_0123) begin
            n_err++;
            $display("FAIL mdu_load: got en=%b data=%h want 1 abcd0123", wb_en_o, wb_data_o);
        end
        mdu_op_i = 1'b0;
        idle_inputs();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_stall();
        test_flush();
        test_back_to_back();
`ifdef MEMWB_MDU_EN
        test_mdu();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
